// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap sequencer in front of the CSR file.
// Takes synchronous exceptions, raw interrupt lines and MRET from the pipeline.
// Produces mepc/mcause/mtval write strobes and data, mip, mstatus.MIE/MPIE,
// and the pipeline redirect/flush controls.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   exception_valid/cause/pc/tval  retiring instruction raised an exception
//   instr_boundary, retire_pc  clean boundary for interrupts, interrupt epc
//   mret                       MRET retiring
//   mtvec, csr_mepc, mie       current CSR values
//   mstatus_we, mstatus_wdata  CSR write to mstatus (bit3 MIE, bit7 MPIE)
//   ext_irq, timer_irq, sw_irq raw asynchronous interrupt lines
//   mepc_we, mcause_we, mtval_we, mepc, mcause, mtval   CSR write strobes/data
//   mip                        synchronised pending bits (11 ext, 7 timer, 3 sw)
//   mstatus_mie, mstatus_mpie  mstatus bits
//   redirect, redirect_pc      one-cycle redirect strobe and target
//   flush, busy                kill in-flight instructions, sequencer not idle
//
// Build option: define TRAP_VECTORED_EN to honour mtvec mode 01 (vectored
// interrupts). Without it the trap target is always the mtvec base.
module trap_ctrl #(
    parameter int unsigned FLUSH_CYCLES    = 2,
    parameter int unsigned IRQ_SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        exception_valid,
    input  logic [3:0]  exception_cause,
    input  logic [31:0] exception_pc,
    input  logic [31:0] exception_tval,
    input  logic        instr_boundary,
    input  logic [31:0] retire_pc,
    input  logic        mret,
    input  logic [31:0] mtvec,
    input  logic [31:0] csr_mepc,
    input  logic [31:0] mie,
    input  logic        mstatus_we,
    input  logic [31:0] mstatus_wdata,
    input  logic        ext_irq,
    input  logic        timer_irq,
    input  logic        sw_irq,
    output logic        mepc_we,
    output logic        mcause_we,
    output logic        mtval_we,
    output logic [31:0] mepc,
    output logic [31:0] mcause,
    output logic [31:0] mtval,
    output logic [31:0] mip,
    output logic        mstatus_mie,
    output logic        mstatus_mpie,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic        busy
);

    localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int unsigned SYN_W = IRQ_SYNC_STAGES;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] TRAP  = 2'd1;
    localparam logic [1:0] RET   = 2'd2;
    localparam logic [1:0] FLUSH = 2'd3;

    logic [1:0]       state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [SYN_W-1:0] ext_sync, timer_sync, sw_sync;
    logic             strobe, strobe_d, redirect_d, flush_d;
    logic             mie_d, mpie_d;
    logic [31:0]      mepc_d, mcause_d, mtval_d, redirect_pc_d;
    logic             ext_s, timer_s, sw_s;
    logic             irq_take;
    logic [3:0]       irq_code;
    logic [31:0]      base, irq_target;
    logic             unused;

    // Interrupt line synchronisers (level sensitive)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_sync   <= '0;
            timer_sync <= '0;
            sw_sync    <= '0;
        end else begin
            ext_sync   <= {ext_sync[SYN_W-2:0], ext_irq};
            timer_sync <= {timer_sync[SYN_W-2:0], timer_irq};
            sw_sync    <= {sw_sync[SYN_W-2:0], sw_irq};
        end
    end

    assign ext_s   = ext_sync[SYN_W-1];
    assign timer_s = timer_sync[SYN_W-1];
    assign sw_s    = sw_sync[SYN_W-1];
    assign mip     = {20'b0, ext_s, 3'b0, timer_s, 3'b0, sw_s, 3'b0};

    // Interrupt selection: ext > sw > timer
    always_comb begin
        irq_code = 4'd7;
        if (ext_s && mie[11]) begin
            irq_code = 4'd11;
        end else if (sw_s && mie[3]) begin
            irq_code = 4'd3;
        end
    end

    assign irq_take = mstatus_mie && instr_boundary &&
                      ((ext_s && mie[11]) || (sw_s && mie[3]) || (timer_s && mie[7]));
    assign base     = {mtvec[31:2], 2'b00};

`ifdef TRAP_VECTORED_EN
    assign irq_target = (mtvec[1:0] == 2'b01) ? base + {26'b0, irq_code, 2'b00} : base;
`else
    assign irq_target = base;
`endif

    // Next state and next registered-output values
    always_comb begin
        state_d       = state;
        cnt_d         = cnt;
        strobe_d      = 1'b0;
        redirect_d    = 1'b0;
        mie_d         = mstatus_mie;
        mpie_d        = mstatus_mpie;
        mepc_d        = mepc;
        mcause_d      = mcause;
        mtval_d       = mtval;
        redirect_pc_d = redirect_pc;
        case (state)
            IDLE: begin
                if (exception_valid) begin
                    state_d       = TRAP;
                    strobe_d      = 1'b1;
                    redirect_d    = 1'b1;
                    mepc_d        = exception_pc;
                    mcause_d      = {28'b0, exception_cause};
                    mtval_d       = exception_tval;
                    redirect_pc_d = base;
                    mpie_d        = mstatus_mie;
                    mie_d         = 1'b0;
                end else if (mret) begin
                    state_d       = RET;
                    redirect_d    = 1'b1;
                    redirect_pc_d = csr_mepc;
                    mie_d         = mstatus_mpie;
                    mpie_d        = 1'b1;
                end else if (irq_take) begin
                    state_d       = TRAP;
                    strobe_d      = 1'b1;
                    redirect_d    = 1'b1;
                    mepc_d        = retire_pc;
                    mcause_d      = {1'b1, 27'b0, irq_code};
                    mtval_d       = 32'b0;
                    redirect_pc_d = irq_target;
                    mpie_d        = mstatus_mie;
                    mie_d         = 1'b0;
                end else if (mstatus_we) begin
                    mie_d  = mstatus_wdata[3];
                    mpie_d = mstatus_wdata[7];
                end
            end
            TRAP, RET: begin
                state_d = FLUSH;
                cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
            end
            FLUSH: begin
                if (cnt == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        flush_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            strobe       <= 1'b0;
            redirect     <= 1'b0;
            flush        <= 1'b0;
            busy         <= 1'b0;
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mepc         <= 32'b0;
            mcause       <= 32'b0;
            mtval        <= 32'b0;
            redirect_pc  <= 32'b0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            strobe       <= strobe_d;
            redirect     <= redirect_d;
            flush        <= flush_d;
            busy         <= flush_d;
            mstatus_mie  <= mie_d;
            mstatus_mpie <= mpie_d;
            mepc         <= mepc_d;
            mcause       <= mcause_d;
            mtval        <= mtval_d;
            redirect_pc  <= redirect_pc_d;
        end
    end

    assign mepc_we   = strobe;
    assign mcause_we = strobe;
    assign mtval_we  = strobe;

    // CSR bits this block does not look at
    assign unused = ^{mie[31:12], mie[10:8], mie[6:4], mie[2:0],
                      mstatus_wdata[31:8], mstatus_wdata[6:4], mstatus_wdata[2:0],
                      mtvec[1:0]};

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: table of trap/MRET/interrupt scenarios
// with a scoreboard of expected redirect-cycle values, plus hand-written
// sequences for synchroniser latency, busy-period filtering and reset abort.
module tb_trap_ctrl;

    localparam int unsigned FC = 2;

`ifdef TRAP_VECTORED_EN
    localparam bit VECTORED = 1'b1;
`else
    localparam bit VECTORED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        exception_valid;
    logic [3:0]  exception_cause;
    logic [31:0] exception_pc, exception_tval;
    logic        instr_boundary;
    logic [31:0] retire_pc;
    logic        mret;
    logic [31:0] mtvec, csr_mepc, mie;
    logic        mstatus_we;
    logic [31:0] mstatus_wdata;
    logic        ext_irq, timer_irq, sw_irq;
    logic        mepc_we, mcause_we, mtval_we;
    logic [31:0] mepc, mcause, mtval, mip;
    logic        mstatus_mie, mstatus_mpie;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush, busy;

    trap_ctrl #(.FLUSH_CYCLES(FC), .IRQ_SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .exception_valid(exception_valid), .exception_cause(exception_cause),
        .exception_pc(exception_pc), .exception_tval(exception_tval),
        .instr_boundary(instr_boundary), .retire_pc(retire_pc), .mret(mret),
        .mtvec(mtvec), .csr_mepc(csr_mepc), .mie(mie),
        .mstatus_we(mstatus_we), .mstatus_wdata(mstatus_wdata),
        .ext_irq(ext_irq), .timer_irq(timer_irq), .sw_irq(sw_irq),
        .mepc_we(mepc_we), .mcause_we(mcause_we), .mtval_we(mtval_we),
        .mepc(mepc), .mcause(mcause), .mtval(mtval), .mip(mip),
        .mstatus_mie(mstatus_mie), .mstatus_mpie(mstatus_mpie),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .flush(flush), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        exc, mret, bnd;
        logic [2:0]  irq;              // {ext, timer, sw}
        logic [31:0] mie_csr;
        logic        st_mie, st_mpie;
        logic [3:0]  cause;
        logic [31:0] pc, tval, retire, mtvec, csr_mepc;
        logic        evt, trap;
        logic [31:0] e_mcause, e_mepc, e_mtval, e_rpc;
        logic        e_mie, e_mpie;
    } vec_t;

    typedef struct {
        string       name;
        logic        trap;
        logic [31:0] mcause, mepc, mtval, rpc;
        logic        mie, mpie;
    } exp_t;

    exp_t q[$];
    int   total  = 0;
    int   passed = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endfunction

    function automatic vec_t mk(input string name, input logic exc, input logic mr,
                                input logic [2:0] irq, input logic bnd, input logic [31:0] mie_csr,
                                input logic smie, input logic smpie, input logic [3:0] cause,
                                input logic [31:0] pc, input logic [31:0] tval,
                                input logic [31:0] retire, input logic [31:0] tvec,
                                input logic [31:0] cmepc, input logic evt, input logic trap,
                                input logic [31:0] emc, input logic [31:0] eme,
                                input logic [31:0] emt, input logic [31:0] erpc,
                                input logic emie, input logic empie);
        vec_t v;
        v.name = name; v.exc = exc; v.mret = mr; v.irq = irq; v.bnd = bnd;
        v.mie_csr = mie_csr; v.st_mie = smie; v.st_mpie = smpie; v.cause = cause;
        v.pc = pc; v.tval = tval; v.retire = retire; v.mtvec = tvec; v.csr_mepc = cmepc;
        v.evt = evt; v.trap = trap; v.e_mcause = emc; v.e_mepc = eme; v.e_mtval = emt;
        v.e_rpc = erpc; v.e_mie = emie; v.e_mpie = empie;
        return v;
    endfunction

    // Scoreboard consumer: compares every redirect cycle against the queue head
    always @(negedge clk) begin
        if (rst_n) begin
            if (redirect) begin
                if (q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_redirect: got redirect to 0x%08h expected none", redirect_pc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk({e.name, "_strobes"}, {29'b0, mepc_we, mcause_we, mtval_we}, {29'b0, {3{e.trap}}});
                    if (e.trap) begin
                        chk({e.name, "_mepc"}, mepc, e.mepc);
                        chk({e.name, "_mcause"}, mcause, e.mcause);
                        chk({e.name, "_mtval"}, mtval, e.mtval);
                    end
                    chk({e.name, "_rpc"}, redirect_pc, e.rpc);
                    chk({e.name, "_mie_mpie"}, {30'b0, mstatus_mie, mstatus_mpie}, {30'b0, e.mie, e.mpie});
                    chk({e.name, "_flush_busy"}, {30'b0, flush, busy}, 32'd3);
                end
            end else begin
                chk("stray_strobe", {29'b0, mepc_we, mcause_we, mtval_we}, 32'd0);
            end
        end
    end

    task automatic idle_inputs();
        exception_valid = 1'b0; exception_cause = 4'd0; exception_pc = 32'd0;
        exception_tval = 32'd0; instr_boundary = 1'b0; retire_pc = 32'd0; mret = 1'b0;
        mstatus_we = 1'b0; mstatus_wdata = 32'd0;
        ext_irq = 1'b0; timer_irq = 1'b0; sw_irq = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk({name, "_idle_timeout"}, {31'b0, ok}, 32'd1);
    endtask

    task automatic write_mstatus(input logic m, input logic p);
        mstatus_we    = 1'b1;
        mstatus_wdata = {24'b0, p, 3'b0, m, 3'b0};
        @(negedge clk);
        mstatus_we    = 1'b0;
        mstatus_wdata = 32'd0;
    endtask

    task automatic run_vec(input vec_t v);
        int   n;
        exp_t e;
        idle_inputs();
        wait_idle(v.name);
        repeat (4) @(negedge clk);
        mtvec    = v.mtvec;
        mie      = v.mie_csr;
        csr_mepc = v.csr_mepc;
        write_mstatus(v.st_mie, v.st_mpie);
        chk({v.name, "_mstatus_wr"}, {30'b0, mstatus_mie, mstatus_mpie}, {30'b0, v.st_mie, v.st_mpie});
        ext_irq = v.irq[2]; timer_irq = v.irq[1]; sw_irq = v.irq[0];
        repeat (3) @(negedge clk);
        chk({v.name, "_mip"}, mip, {20'b0, v.irq[2], 3'b0, v.irq[1], 3'b0, v.irq[0], 3'b0});
        exception_valid = v.exc; exception_cause = v.cause; exception_pc = v.pc;
        exception_tval = v.tval; mret = v.mret; instr_boundary = v.bnd; retire_pc = v.retire;
        if (v.evt) begin
            e.name = v.name; e.trap = v.trap; e.mcause = v.e_mcause; e.mepc = v.e_mepc;
            e.mtval = v.e_mtval; e.rpc = v.e_rpc; e.mie = v.e_mie; e.mpie = v.e_mpie;
            q.push_back(e);
        end
        @(negedge clk);
        exception_valid = 1'b0; mret = 1'b0; instr_boundary = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (!flush) break;
            n++;
            @(negedge clk);
        end
        chk({v.name, "_flush_len"}, 32'(n), v.evt ? 32'(FC + 1) : 32'd0);
        chk({v.name, "_status_after"}, {30'b0, mstatus_mie, mstatus_mpie}, {30'b0, v.e_mie, v.e_mpie});
        chk({v.name, "_sb_drained"}, 32'(q.size()), 32'd0);
        ext_irq = 1'b0; timer_irq = 1'b0; sw_irq = 1'b0;
    endtask

    vec_t vt[13];

    initial begin
        exp_t e;
        vt[0]  = mk("exc_basic", 1, 0, 3'b000, 0, 32'h0, 1, 0, 4'd2, 32'h100, 32'hDEAD, 32'h0, 32'h8000, 32'h0,
                    1, 1, 32'h2, 32'h100, 32'hDEAD, 32'h8000, 0, 1);
        vt[1]  = mk("timer_irq", 0, 0, 3'b010, 1, 32'h80, 1, 0, 4'd0, 32'h0, 32'h0, 32'h204, 32'h8000, 32'h0,
                    1, 1, 32'h80000007, 32'h204, 32'h0, 32'h8000, 0, 1);
        vt[2]  = mk("exc_beats_irq", 1, 0, 3'b110, 1, 32'h880, 1, 0, 4'd5, 32'h300, 32'h12, 32'h400, 32'h8000, 32'h0,
                    1, 1, 32'h5, 32'h300, 32'h12, 32'h8000, 0, 1);
        vt[3]  = mk("ext_beats_timer", 0, 0, 3'b110, 1, 32'h880, 1, 0, 4'd0, 32'h0, 32'h0, 32'h400, 32'h8000, 32'h0,
                    1, 1, 32'h8000000B, 32'h400, 32'h0, 32'h8000, 0, 1);
        vt[4]  = mk("mret_basic", 0, 1, 3'b000, 0, 32'h0, 0, 1, 4'd0, 32'h0, 32'h0, 32'h0, 32'h8000, 32'h204,
                    1, 0, 32'h0, 32'h0, 32'h0, 32'h204, 1, 1);
        vt[5]  = mk("timer_vec", 0, 0, 3'b010, 1, 32'h80, 1, 1, 4'd0, 32'h0, 32'h0, 32'h500, 32'h8001, 32'h0,
                    1, 1, 32'h80000007, 32'h500, 32'h0, VECTORED ? 32'h801C : 32'h8000, 0, 1);
        vt[6]  = mk("sw_beats_timer", 0, 0, 3'b011, 1, 32'h88, 1, 0, 4'd0, 32'h0, 32'h0, 32'h600, 32'h8001, 32'h0,
                    1, 1, 32'h80000003, 32'h600, 32'h0, VECTORED ? 32'h800C : 32'h8000, 0, 1);
        vt[7]  = mk("irq_mie_off", 0, 0, 3'b010, 1, 32'h80, 0, 0, 4'd0, 32'h0, 32'h0, 32'h700, 32'h8000, 32'h0,
                    0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0);
        vt[8]  = mk("irq_no_boundary", 0, 0, 3'b100, 0, 32'h800, 1, 0, 4'd0, 32'h0, 32'h0, 32'h700, 32'h8000, 32'h0,
                    0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0);
        vt[9]  = mk("irq_masked", 0, 0, 3'b001, 1, 32'h880, 1, 0, 4'd0, 32'h0, 32'h0, 32'h700, 32'h8000, 32'h0,
                    0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0);
        vt[10] = mk("exc_mie_off_vec_base", 1, 0, 3'b000, 0, 32'h0, 0, 1, 4'd11, 32'h700, 32'h0, 32'h0, 32'h8001, 32'h0,
                    1, 1, 32'hB, 32'h700, 32'h0, 32'h8000, 0, 0);
        vt[11] = mk("mret_mpie0", 0, 1, 3'b000, 0, 32'h0, 1, 0, 4'd0, 32'h0, 32'h0, 32'h0, 32'h8000, 32'h1000,
                    1, 0, 32'h0, 32'h0, 32'h0, 32'h1000, 0, 1);
        vt[12] = mk("exc_beats_mret", 1, 1, 3'b000, 0, 32'h0, 1, 1, 4'd3, 32'h800, 32'h4, 32'h0, 32'h8000, 32'h1000,
                    1, 1, 32'h3, 32'h800, 32'h4, 32'h8000, 0, 1);

        idle_inputs();
        mtvec = 32'h8000; csr_mepc = 32'h0; mie = 32'h0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {26'b0, flush, busy, redirect, mepc_we, mstatus_mie, mstatus_mpie}, 32'd0);
        chk("reset_data", mepc | mcause | mtval | redirect_pc | mip, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Synchroniser latency: two edges before mip shows the line
        timer_irq = 1'b1;
        @(negedge clk);
        chk("mip_sync_1", mip, 32'h0);
        @(negedge clk);
        chk("mip_sync_2", mip, 32'h80);
        timer_irq = 1'b0;
        repeat (2) @(negedge clk);
        chk("mip_release", mip, 32'h0);

        foreach (vt[i]) run_vec(vt[i]);

        // Busy period ignores a second exception and mstatus writes; trap beats same-edge write
        idle_inputs();
        wait_idle("busy_filter");
        repeat (4) @(negedge clk);
        mtvec = 32'h8000; mie = 32'h0;
        write_mstatus(1'b1, 1'b0);
        exception_valid = 1'b1; exception_cause = 4'd1; exception_pc = 32'h900; exception_tval = 32'h55;
        mstatus_we = 1'b1; mstatus_wdata = 32'h08;
        e.name = "busy_filter"; e.trap = 1'b1; e.mcause = 32'h1; e.mepc = 32'h900; e.mtval = 32'h55;
        e.rpc = 32'h8000; e.mie = 1'b0; e.mpie = 1'b1;
        q.push_back(e);
        @(negedge clk);
        exception_cause = 4'd7; exception_pc = 32'hA00; exception_tval = 32'h66;
        repeat (3) @(negedge clk);
        idle_inputs();
        repeat (5) @(negedge clk);
        chk("busy_filter_mcause", mcause, 32'h1);
        chk("busy_filter_mepc", mepc, 32'h900);
        chk("busy_filter_status", {30'b0, mstatus_mie, mstatus_mpie}, 32'd1);
        chk("busy_filter_idle", {31'b0, busy}, 32'd0);

        // Reset during FLUSH aborts at once and leaves the block idle
        write_mstatus(1'b1, 1'b0);
        exception_valid = 1'b1; exception_cause = 4'd4; exception_pc = 32'hB00; exception_tval = 32'h77;
        e.name = "reset_abort"; e.trap = 1'b1; e.mcause = 32'h4; e.mepc = 32'hB00; e.mtval = 32'h77;
        e.rpc = 32'h8000; e.mie = 1'b0; e.mpie = 1'b1;
        q.push_back(e);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        chk("reset_abort_in_flush", {31'b0, flush}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("reset_abort_ctrl", {26'b0, flush, busy, redirect, mepc_we, mstatus_mie, mstatus_mpie}, 32'd0);
        chk("reset_abort_data", mepc | mcause | mtval | redirect_pc, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("reset_abort_after", {30'b0, busy, redirect}, 32'd0);
        chk("reset_abort_sb", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
